// File: rtl/demux1to16_capture_if.sv
// Serial-to-word capture bus: serial write side plus the completed-word handshake.
interface demux1to16_capture_if;
  logic        din;
  logic        din_valid;
  logic        mode;
  logic [3:0]  select;
  logic        clear;
  logic        word_ready;
  logic [15:0] data_out;
  logic [15:0] fill_mask;
  logic        word_valid;
  logic [3:0]  bit_index;
  logic        overrun;

  modport master (
    output din, din_valid, mode, select, clear, word_ready,
    input  data_out, fill_mask, word_valid, bit_index, overrun
  );

  modport slave (
    input  din, din_valid, mode, select, clear, word_ready,
    output data_out, fill_mask, word_valid, bit_index, overrun
  );
endinterface

// File: rtl/demux1to16_capture.sv
// 1-to-16 serial bit demultiplexer that assembles a 16-bit word, then holds it
// until the consumer releases it. Each bit position lives in its own cell.
module demux1to16_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic wr_en,
  input  logic rel,
  input  logic din,
  output logic d,
  output logic f
);
  // wr_en only fires in FILL and rel only in HOLD, so they never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= 1'b0;
      f <= 1'b0;
    end else if (clear) begin
      d <= 1'b0;
      f <= 1'b0;
    end else if (wr_en) begin
      d <= din;
      f <= 1'b1;
    end else if (rel) begin
      f <= 1'b0;
    end
  end
endmodule

module demux1to16_capture (
  input  logic clk,
  input  logic rst_n,
  demux1to16_capture_if.slave bus
);
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [3:0]  bit_idx;
  logic [3:0]  wr_idx;
  logic [15:0] wr_sel;
  logic [15:0] data_q;
  logic [15:0] fill_q;
  logic        accept;
  logic        rel;
  logic        complete;
  logic        ovr_q;

  always_comb begin
    wr_idx   = bus.mode ? bit_idx : bus.select;
    accept   = (state == FILL) && bus.din_valid && !bus.clear;
    rel      = (state == HOLD) && bus.word_ready && !bus.clear;
    wr_sel   = '0;
    if (accept) wr_sel[wr_idx] = 1'b1;
    complete = accept && (&(fill_q | wr_sel));
  end

  for (genvar i = 0; i < 16; i++) begin : g_bit
    demux1to16_bit u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (bus.clear),
      .wr_en (wr_sel[i]),
      .rel   (rel),
      .din   (bus.din),
      .d     (data_q[i]),
      .f     (fill_q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL:    if (complete)       state_nxt = HOLD;
        HOLD:    if (bus.word_ready) state_nxt = FILL;
        default: state_nxt = FILL;
      endcase
    end
  end

  // Counter only moves on accepted sequential writes; mode flips leave it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= 4'd0;
      ovr_q   <= 1'b0;
    end else if (bus.clear) begin
      bit_idx <= 4'd0;
      ovr_q   <= 1'b0;
    end else begin
      if (rel)                    bit_idx <= 4'd0;
      else if (accept && bus.mode) bit_idx <= bit_idx + 4'd1;
      if ((state == HOLD) && bus.din_valid) ovr_q <= 1'b1;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.fill_mask  = fill_q;
  assign bus.word_valid = (state == HOLD);
  assign bus.bit_index  = bit_idx;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_demux1to16_capture.sv
// Randomized and directed bench for demux1to16_capture against a word-level model.
module tb_demux1to16_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic chk_en = 1'b0;

  demux1to16_capture_if bus();

  demux1to16_capture dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: a word is complete exactly when every index has been written
  logic [15:0] m_data, m_mask;
  logic [3:0]  m_idx;
  logic        m_ovr;
  int          k;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.clear) begin
      m_data = '0; m_mask = '0; m_idx = '0; m_ovr = 1'b0;
    end else if (m_mask == 16'hFFFF) begin
      if (bus.din_valid) m_ovr = 1'b1;
      if (bus.word_ready) begin m_mask = '0; m_idx = '0; end
    end else if (bus.din_valid) begin
      k = bus.mode ? int'(m_idx) : int'(bus.select);
      m_data[k] = bus.din;
      m_mask[k] = 1'b1;
      if (bus.mode) m_idx = 4'((int'(m_idx) + 1) % 16);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("data_out",   bus.data_out, m_data);
      chk("fill_mask",  bus.fill_mask, m_mask);
      chk("word_valid", 16'(bus.word_valid), 16'(m_mask == 16'hFFFF));
      chk("bit_index",  16'(bus.bit_index), 16'(m_idx));
      chk("overrun",    16'(bus.overrun), 16'(m_ovr));
    end
  end

  task automatic step(input logic dv, input logic d, input logic m,
                      input logic [3:0] sel, input logic clr, input logic rdy);
    bus.din_valid  = dv;
    bus.din        = d;
    bus.mode       = m;
    bus.select     = sel;
    bus.clear      = clr;
    bus.word_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, bus.data_out, 16'h0000);
    chk({tag, "_mask"}, bus.fill_mask, 16'h0000);
    chk({tag, "_wv"},   16'(bus.word_valid), 16'd0);
    chk({tag, "_idx"},  16'(bus.bit_index), 16'd0);
    chk({tag, "_ovr"},  16'(bus.overrun), 16'd0);
  endtask

  logic [15:0] pat;

  initial begin
    bus.din = 0; bus.din_valid = 0; bus.mode = 0; bus.select = 0;
    bus.clear = 0; bus.word_ready = 0;
    #3 chk_reset_vals("reset");
    #4 rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Sequential fill of A5C3, LSB first
    pat = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, pat[i], 1'b1, 4'($urandom), 1'b0, 1'b0);
      if (i == 14) chk("seq_not_early", 16'(bus.word_valid), 16'd0);
    end
    chk("seq_data", bus.data_out, 16'hA5C3);
    chk("seq_wv",   16'(bus.word_valid), 16'd1);
    chk("seq_idx",  16'(bus.bit_index), 16'd0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("rel_wv",   16'(bus.word_valid), 16'd0);
    chk("rel_mask", bus.fill_mask, 16'h0000);

    // Addressed fill 15..0 after a duplicate to index 3
    step(1'b1, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
    for (int s = 15; s >= 0; s--) begin
      step(1'b1, (s % 2 == 0), 1'b0, 4'(s), 1'b0, 1'b0);
      if (s == 1) chk("addr_dup_not_early", 16'(bus.word_valid), 16'd0);
    end
    chk("addr_data", bus.data_out, 16'h5555);
    chk("addr_mask", bus.fill_mask, 16'hFFFF);
    chk("addr_wv",   16'(bus.word_valid), 16'd1);

    // Backpressure with writes dropped
    repeat (5) begin
      step(1'b1, 1'($urandom), 1'($urandom), 4'($urandom), 1'b0, 1'b0);
      chk("bp_data", bus.data_out, 16'h5555);
    end
    chk("bp_ovr", 16'(bus.overrun), 16'd1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    chk("bp_rel_wv",   16'(bus.word_valid), 16'd0);
    chk("bp_rel_mask", bus.fill_mask, 16'h0000);
    chk("bp_rel_ovr",  16'(bus.overrun), 16'd1);
    chk("bp_rel_data", bus.data_out, 16'h5555);

    // Release coinciding with a write
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    chk("clr_ovr", 16'(bus.overrun), 16'd0);
    pat = 16'($urandom);
    for (int i = 0; i < 16; i++) step(1'b1, pat[i], 1'b1, 4'd0, 1'b0, 1'b0);
    chk("sim_fill", bus.data_out, pat);
    step(1'b1, ~pat[0], 1'b1, 4'd0, 1'b0, 1'b1);
    chk("sim_mask", bus.fill_mask, 16'h0000);
    chk("sim_ovr",  16'(bus.overrun), 16'd1);
    chk("sim_data", bus.data_out, pat);

    // Clear beats a write at half fill
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
    chk("half_mask", bus.fill_mask, 16'h00FF);
    chk("half_idx",  16'(bus.bit_index), 16'd8);
    step(1'b1, 1'b1, 1'b1, 4'd8, 1'b1, 1'b1);
    chk_reset_vals("clear");

    // Async reset between edges with 10 bits filled
    for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom), 1'b1, 4'd0, 1'b0, 1'b0);
    chk("pre_rst_mask", bus.fill_mask, 16'h03FF);
    bus.din_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    #1 rst_n = 1'b1;
    pat = 16'($urandom);
    for (int i = 0; i < 16; i++) step(1'b1, pat[i], 1'b1, 4'd0, 1'b0, 1'b0);
    chk("refill_wv",   16'(bus.word_valid), 16'd1);
    chk("refill_data", bus.data_out, pat);

    // Randomized traffic
    repeat (400)
      step(($urandom % 5) != 0, 1'($urandom), 1'($urandom), 4'($urandom),
           ($urandom % 40) == 0, ($urandom % 3) == 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
